sensor_sweep: RTL and testbench
===============================

// Module: sensor_sweep
// PURPOSE
//  Drives the 4-bit sensor bus through every code 0..2**NUM_SENSORS-1 and samples the returned error line for each code.
//  Builds a per-code error map and an error count; a bench or self-test controller reads them after the done pulse.
//  Acts as the stimulus (driving) end of the sensor/error interface; the error detector under test sits between sensors and error_in.
// PARAMETERS
//  NUM_SENSORS  4  width of sensor bus; sweep length = 2**NUM_SENSORS codes
//  HOLD_CYCLES  2  clocks each code is held before error_in is sampled (legal >= 1)
// PORTS
//  clk          in   1                     system clock, rising edge
//  n_rst        in   1                     asynchronous, active-low reset
//  start        in   1                     begin sweep; honoured only in IDLE
//  error_in     in   1                     error response for the currently driven code
//  sensors      out  NUM_SENSORS           registered code driven to detector
//  busy         out  1                     high while sweep in progress (DRIVE)
//  done         out  1                     one-cycle pulse after last sample
//  error_map    out  2**NUM_SENSORS        bit c = error_in sampled while code c driven
//  error_count  out  NUM_SENSORS+1         number of set bits in error_map
// BEHAVIOUR
//  Reset (n_rst=0, async): state=IDLE; sensors=0; busy=0; done=0; error_map=0; error_count=0; code=0; hold_cnt=0.
//  States: IDLE -> DRIVE -> DONE -> IDLE. All outputs registered.
//  IDLE:  sensors=0, busy=0. start=1 at edge E0: clear error_map/error_count, code=0, hold_cnt=0, -> DRIVE.
//  DRIVE: sensors=code, busy=1. hold_cnt increments each edge.
//         At an edge with hold_cnt==HOLD_CYCLES-1, this is the sample edge:
//         - error_map[code] <= error_in.
//         - error_count += error_in.
//         - hold_cnt <= 0.
//         - If code==max: -> DONE. Else code <= code+1.
//  Timing: code c is on sensors from edge E0+c*H to edge E0+(c+1)*H (H=HOLD_CYCLES).
//         It is sampled at edge E0+(c+1)*H. A sweep occupies exactly 2**NUM_SENSORS*H cycles with busy=1.
//  DONE:  entered at edge E0+16H for the default NUM_SENSORS=4.
//         done=1, busy=0, sensors=0 for one cycle, then -> IDLE (done=0).
//  error_map/error_count hold their values from DONE until the next accepted start.
//  Boundary conditions:
//  - start while DRIVE or DONE: ignored; no restart and no clear.
//  - start held high continuously: a new sweep begins at the first IDLE edge after DONE.
//  - code wrap: never wraps. The max code is sampled once, then the block exits to DONE.
//  - error_count width covers all-ones (16 for NUM_SENSORS=4) without overflow.
//  - error_in is treated as synchronous/combinational from sensors. It is sampled only at sample edges; all other cycles are don't-care.
//  - n_rst mid-sweep: immediate return to reset values. Partial map discarded; no done pulse.
// STRUCTURE
//  sensor_sweep_pkg contains:
//  - typedef enum logic [1:0] {IDLE, DRIVE, DONE} sweep_state_t.
//  - default constants NUM_SENSORS_DEF=4, HOLD_CYCLES_DEF=2.
//  Sub-module sweep_hold_timer: clear/enable counter with terminal-count flag at HOLD_CYCLES-1.
//  The code counter, FSM, and map/count registers stay in sensor_sweep.
// TESTING (bench models error = s0 | s1&s3 | s1&s2 combinationally on sensors)
//  1. Reset, pulse start, H=2 -> busy high 32 cycles; done pulses at E0+32.
//     error_map=16'hEEEA, error_count=11.
//  2. error_in tied 0 / tied 1 -> error_map=16'h0000 with count=0, and 16'hFFFF with count=16.
//  3. HOLD_CYCLES=1 build -> sensors steps 0..15 on consecutive edges; done at E0+16; same map 16'hEEEA.
//  4. Extra start pulses at E0+5 and in DONE cycle -> no restart; map unchanged; single done pulse.
//  5. n_rst low at E0+9 -> all outputs 0 asynchronously, no done.
//     A new start then gives a full 16'hEEEA sweep.
//  6. error_in toggled on non-sample cycles only -> ignored; map reflects sample-edge values only.

Source files
------------

// File: rtl/sensor_sweep_pkg.sv
// Shared types and default constants for the sensor sweep block.
package sensor_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  localparam int NUM_SENSORS_DEF = 4;
  localparam int HOLD_CYCLES_DEF = 2;

endpackage

// File: rtl/sweep_hold_timer.sv
// Hold timer: counts clocks a code has been driven; tc marks the sample edge.
module sweep_hold_timer
  import sensor_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  // A one-clock hold still needs a 1-bit counter that just stays at zero.
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] hold_cnt;

  // Count up while enabled, return to zero after the terminal count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_cnt <= '0;
    end else if (clear) begin
      hold_cnt <= '0;
    end else if (enable) begin
      if (tc) hold_cnt <= '0;
      else    hold_cnt <= hold_cnt + CW'(1);
    end
  end

  assign tc = (hold_cnt == TC_VAL);

endmodule

// File: rtl/sensor_sweep.sv
// Sensor sweep stimulus: walks every sensor code, records the error response
// of each into a map and keeps a running error count.
//
//  state | meaning
//  IDLE  | sensors parked at 0, waiting for start
//  DRIVE | driving code, sampling error_in at each hold terminal count
//  DONE  | one-cycle done pulse, results held
module sensor_sweep
  import sensor_sweep_pkg::*;
#(
  parameter int NUM_SENSORS = NUM_SENSORS_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      start,
  input  logic                      error_in,
  output logic [NUM_SENSORS-1:0]    sensors,
  output logic                      busy,
  output logic                      done,
  output logic [2**NUM_SENSORS-1:0] error_map,
  output logic [NUM_SENSORS:0]      error_count
);

  localparam logic [NUM_SENSORS-1:0] CODE_MAX = '1;

  sweep_state_t state, next_state;
  logic [NUM_SENSORS-1:0] code;
  logic sample;
  logic last_sample;

  sweep_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (state != DRIVE),
    .enable (state == DRIVE),
    .tc     (sample)
  );

  assign last_sample = sample && (code == CODE_MAX);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = DRIVE;
      DRIVE:   if (last_sample) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs, code counter and result map/count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sensors     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error_map   <= '0;
      error_count <= '0;
      code        <= '0;
    end else begin
      case (state)
        IDLE: begin
          sensors <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            error_map   <= '0;
            error_count <= '0;
            code        <= '0;
            busy        <= 1'b1;
          end
        end
        DRIVE: begin
          if (sample) begin
            error_map[code] <= error_in;
            error_count     <= error_count + (NUM_SENSORS + 1)'(error_in);
            if (code == CODE_MAX) begin
              sensors <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              code    <= code + NUM_SENSORS'(1);
              sensors <= code + NUM_SENSORS'(1);
            end
          end
        end
        DONE: begin
          sensors <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          sensors <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_sweep.sv
// Directed bench for sensor_sweep: one default build (H=2) and one H=1 build.
module tb_sensor_sweep;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic        error_in, error_in1;
  logic [3:0]  sensors, sensors1;
  logic        busy, busy1, done, done1;
  logic [15:0] error_map, error_map1;
  logic [4:0]  error_count, error_count1;

  int   mode = 0;      // 0 model, 1 tied 0, 2 tied 1, 3 model with off-sample flips
  logic flip = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic logic err_model(input logic [3:0] s);
    return s[0] | (s[1] & s[3]) | (s[1] & s[2]);
  endfunction

  always_comb begin
    case (mode)
      1:       error_in = 1'b0;
      2:       error_in = 1'b1;
      default: error_in = err_model(sensors) ^ flip;
    endcase
  end

  assign error_in1 = err_model(sensors1);

  always #5 clk = ~clk;

  sensor_sweep dut (
    .clk(clk), .n_rst(n_rst), .start(start), .error_in(error_in),
    .sensors(sensors), .busy(busy), .done(done),
    .error_map(error_map), .error_count(error_count)
  );

  sensor_sweep #(.NUM_SENSORS(4), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .start(start1), .error_in(error_in1),
    .sensors(sensors1), .busy(busy1), .done(done1),
    .error_map(error_map1), .error_count(error_count1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Run one H=2 sweep; sample #1 after each edge E0+k, k=0..39.
  task automatic sweep(input int md, input bit glitch,
                       output int bc, output int dk, output int dn);
    mode = md; flip = 1'b0; bc = 0; dk = -1; dn = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (busy) bc++;
      if (done) begin dn++; if (dk < 0) dk = k; end
      if (k < 32) chk("sensors", {28'd0, sensors}, k / 2);
      flip = (md == 3) && ((k + 1) % 2 == 1);
      if (glitch) start = (k == 4 || k == 32);
    end
    flip = 1'b0;
  endtask

  int bc, dk, dn;

  initial begin
    // Reset values
    #2;
    chk("rst_sensors", {28'd0, sensors}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_map", {16'd0, error_map}, 0);
    chk("rst_count", {27'd0, error_count}, 0);
    @(negedge clk); n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: model sweep
    sweep(0, 1'b0, bc, dk, dn);
    chk("t1_busy_cycles", bc, 32);
    chk("t1_done_edge", dk, 32);
    chk("t1_done_pulses", dn, 1);
    chk("t1_map", {16'd0, error_map}, 32'hEEEA);
    chk("t1_count", {27'd0, error_count}, 11);

    // Test 2: tied 0 and tied 1
    sweep(1, 1'b0, bc, dk, dn);
    chk("t2_map0", {16'd0, error_map}, 32'h0000);
    chk("t2_count0", {27'd0, error_count}, 0);
    sweep(2, 1'b0, bc, dk, dn);
    chk("t2_map1", {16'd0, error_map}, 32'hFFFF);
    chk("t2_count1", {27'd0, error_count}, 16);
    chk("t2_done_pulses", dn, 1);

    // Test 3: H=1 build
    dk = -1; dn = 0; bc = 0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k < 16) chk("t3_sensors", {28'd0, sensors1}, k);
      if (busy1) bc++;
      if (done1) begin dn++; if (dk < 0) dk = k; end
    end
    chk("t3_busy_cycles", bc, 16);
    chk("t3_done_edge", dk, 16);
    chk("t3_done_pulses", dn, 1);
    chk("t3_map", {16'd0, error_map1}, 32'hEEEA);
    chk("t3_count", {27'd0, error_count1}, 11);

    // Test 4: extra starts mid-sweep and in DONE
    sweep(0, 1'b1, bc, dk, dn);
    chk("t4_busy_cycles", bc, 32);
    chk("t4_done_edge", dk, 32);
    chk("t4_done_pulses", dn, 1);
    chk("t4_map", {16'd0, error_map}, 32'hEEEA);
    chk("t4_count", {27'd0, error_count}, 11);

    // Test 5: reset at E0+9, then a clean sweep
    mode = 0; dn = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 9; k++) begin @(posedge clk); #1; end
    chk("t5_partial_count", {27'd0, error_count}, 2);
    chk("t5_partial_busy", {31'd0, busy}, 1);
    n_rst = 1'b0;
    #1;
    chk("t5_rst_sensors", {28'd0, sensors}, 0);
    chk("t5_rst_busy", {31'd0, busy}, 0);
    chk("t5_rst_done", {31'd0, done}, 0);
    chk("t5_rst_map", {16'd0, error_map}, 0);
    chk("t5_rst_count", {27'd0, error_count}, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("t5_no_done", dn, 0);
    sweep(0, 1'b0, bc, dk, dn);
    chk("t5_done_edge", dk, 32);
    chk("t5_map", {16'd0, error_map}, 32'hEEEA);
    chk("t5_count", {27'd0, error_count}, 11);

    // Test 6: error_in flipped on non-sample edges only
    sweep(3, 1'b0, bc, dk, dn);
    chk("t6_map", {16'd0, error_map}, 32'hEEEA);
    chk("t6_count", {27'd0, error_count}, 11);

    // Test 7: start held high restarts at the first IDLE edge after DONE
    mode = 0; dk = -1;
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 80 && dk < 0; k++) begin
      @(posedge clk); #1;
      if (done) dk = k;
    end
    chk("t7_first_done_seen", {31'd0, dk >= 0}, 1);
    chk("t7_map_at_done", {16'd0, error_map}, 32'hEEEA);
    @(posedge clk); #1;
    chk("t7_busy_idle", {31'd0, busy}, 0);
    @(posedge clk); #1;
    chk("t7_busy_restart", {31'd0, busy}, 1);
    chk("t7_cleared", {27'd0, error_count}, 0);
    start = 1'b0;
    dk = -1;
    for (int k = 0; k < 40 && dk < 0; k++) begin
      @(posedge clk); #1;
      if (done) dk = k;
    end
    chk("t7_second_done_edge", dk, 31);
    chk("t7_second_map", {16'd0, error_map}, 32'hEEEA);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
